// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared states, ASCII command bytes and rate codes for the UART command sequencer.
package uart_cmd_pkg;
    typedef enum logic {ST_NORMAL, ST_CMD} state_t;
    localparam logic [7:0] CH_M_U = 8'h4D;
    localparam logic [7:0] CH_M_L = 8'h6D;
    localparam logic [7:0] CH_F_U = 8'h46;
    localparam logic [7:0] CH_F_L = 8'h66;
    localparam logic [7:0] CH_1   = 8'h31;
    localparam logic [7:0] CH_5   = 8'h35;
    localparam logic [7:0] CH_A_U = 8'h41;
    localparam logic [7:0] CH_A_L = 8'h61;
    localparam logic [7:0] CH_S_U = 8'h53;
    localparam logic [7:0] CH_S_L = 8'h73;
    localparam logic [7:0] CH_P_U = 8'h50;
    localparam logic [7:0] CH_P_L = 8'h70;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_ACK = 8'h4B;
    localparam logic [7:0] CH_NAK = 8'h3F;
    localparam logic [7:0] CH_TO  = 8'h54;
    localparam logic [1:0] RATE_SLOW = 2'b00;
    localparam logic [1:0] RATE_MID  = 2'b01;
    localparam logic [1:0] RATE_FAST = 2'b10;
endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: received-byte strobe and response-byte valid/ready handshake.
interface uart_cmd_sequencer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
    modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);
endinterface

// File: rtl/uart_cmd_tx_slot.sv
// uart_cmd_tx_slot: one-entry response register; a new load always wins over the held byte.
module uart_cmd_tx_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data
);
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        valid_d = load ? 1'b1 : (valid_q && tx_ready) ? 1'b0 : valid_q;
        data_d  = load ? data : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = data_q;
endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: NORMAL/CMD byte protocol driving the display byte, PWM rate/enable and UART responses.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_cmd_sequencer_if.slave         bus,
    output logic [7:0]                  seg_data,
    output logic                        seg_update,
    output logic [1:0]                  rate_sel,
    output logic                        rate_update,
    output logic                        pwm_en,
    output logic                        mode_cmd
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [7:0]      seg_q, seg_d;
    logic [1:0]      rate_q, rate_d;
    logic            pwm_q, pwm_d, seg_upd_q, seg_upd_d, rate_upd_q, rate_upd_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            load;
    logic [7:0]      resp, rx;
    logic            is_blank;

    assign rx       = bus.rx_data;
    assign is_blank = (rx == 8'h00) || (rx == CH_CR) || (rx == CH_LF);

    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        rate_d     = rate_q;
        pwm_d      = pwm_q;
        seg_upd_d  = 1'b0;
        rate_upd_d = 1'b0;
        cnt_d      = (state_q == ST_CMD) ? cnt_q + TO_W'(1) : '0;
        load       = 1'b0;
        resp       = CH_ACK;
        if (bus.rx_valid && state_q == ST_NORMAL) begin
            if (rx == CH_M_U || rx == CH_M_L) begin
                state_d = ST_CMD;
                cnt_d   = '0;
                load    = 1'b1;
            end else if (!(is_blank || rx == CH_F_U || rx == CH_F_L)) begin
                seg_d     = rx;
                seg_upd_d = 1'b1;
                load      = 1'b1;
                resp      = rx;
            end
        end else if (bus.rx_valid) begin
            cnt_d = '0;
            load  = !is_blank;
            case (rx)
                CH_1:           begin rate_d = RATE_SLOW; rate_upd_d = 1'b1; end
                CH_5:           begin rate_d = RATE_MID;  rate_upd_d = 1'b1; end
                CH_A_U, CH_A_L: begin rate_d = RATE_FAST; rate_upd_d = 1'b1; end
                CH_S_U, CH_S_L: pwm_d = 1'b1;
                CH_P_U, CH_P_L: pwm_d = 1'b0;
                CH_F_U, CH_F_L: state_d = ST_NORMAL;
                default:        resp = CH_NAK;
            endcase
        end else if (state_q == ST_CMD && cnt_q == TO_LAST) begin
            // a same-cycle byte takes the branch above, so expiry only fires when idle
            state_d = ST_NORMAL;
            cnt_d   = '0;
            load    = 1'b1;
            resp    = CH_TO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_NORMAL;
            seg_q      <= 8'h00;
            rate_q     <= RATE_SLOW;
            pwm_q      <= 1'b1;
            seg_upd_q  <= 1'b0;
            rate_upd_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            rate_q     <= rate_d;
            pwm_q      <= pwm_d;
            seg_upd_q  <= seg_upd_d;
            rate_upd_q <= rate_upd_d;
            cnt_q      <= cnt_d;
        end
    end

    uart_cmd_tx_slot u_slot (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data     (resp),
        .tx_ready (bus.tx_ready),
        .tx_valid (bus.tx_valid),
        .tx_data  (bus.tx_data)
    );

    assign seg_data    = seg_q;
    assign seg_update  = seg_upd_q;
    assign rate_sel    = rate_q;
    assign rate_update = rate_upd_q;
    assign pwm_en      = pwm_q;
    assign mode_cmd    = (state_q == ST_CMD);
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed scenario bench for the UART command sequencer (TIMEOUT_CYCLES=16).
module tb_uart_cmd_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_data;
    logic       seg_update;
    logic [1:0] rate_sel;
    logic       rate_update;
    logic       pwm_en;
    logic       mode_cmd;
    int         checks = 0;
    int         failures = 0;

    uart_cmd_sequencer_if bus ();

    uart_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .seg_data    (seg_data),
        .seg_update  (seg_update),
        .rate_sel    (rate_sel),
        .rate_update (rate_update),
        .pwm_en      (pwm_en),
        .mode_cmd    (mode_cmd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({mode_cmd, seg_data, rate_sel, pwm_en, seg_update, rate_update, bus.tx_valid, bus.tx_data} !== {1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_state got mode=%b seg=%h rate=%b pwm=%b su=%b ru=%b txv=%b txd=%h", mode_cmd, seg_data, rate_sel, pwm_en, seg_update, rate_update, bus.tx_valid, bus.tx_data);
        end
    endtask

    task automatic test_cmd_entry();
        send(8'h6D);
        checks++;
        if ({mode_cmd, bus.tx_valid, bus.tx_data} !== {1'b1, 1'b1, 8'h4B}) begin
            failures++;
            $display("FAIL enter_cmd got mode=%b txv=%b txd=%h exp 1 1 4b", mode_cmd, bus.tx_valid, bus.tx_data);
        end
        tick();
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_after_handshake got txv=%b exp 0", bus.tx_valid);
        end
        send(8'h35);
        checks++;
        if ({rate_sel, rate_update, bus.tx_valid, bus.tx_data} !== {2'b01, 1'b1, 1'b1, 8'h4B}) begin
            failures++;
            $display("FAIL rate_mid got rate=%b ru=%b txv=%b txd=%h exp 01 1 1 4b", rate_sel, rate_update, bus.tx_valid, bus.tx_data);
        end
        tick();
        checks++;
        if (rate_update !== 1'b0) begin
            failures++;
            $display("FAIL rate_update_pulse got %b exp 0", rate_update);
        end
        send(8'h66);
        checks++;
        if ({mode_cmd, rate_sel, bus.tx_data} !== {1'b0, 2'b01, 8'h4B}) begin
            failures++;
            $display("FAIL exit_cmd got mode=%b rate=%b txd=%h exp 0 01 4b", mode_cmd, rate_sel, bus.tx_data);
        end
        tick();
    endtask

    task automatic test_normal();
        logic [7:0] ign [3] = '{8'h00, 8'h46, 8'h0D};
        send(8'h37);
        checks++;
        if ({seg_data, seg_update, bus.tx_valid, bus.tx_data} !== {8'h37, 1'b1, 1'b1, 8'h37}) begin
            failures++;
            $display("FAIL echo got seg=%h su=%b txv=%b txd=%h exp 37 1 1 37", seg_data, seg_update, bus.tx_valid, bus.tx_data);
        end
        for (int i = 0; i < 3; i++) begin
            send(ign[i]);
            checks++;
            if ({seg_data, seg_update, bus.tx_valid, mode_cmd} !== {8'h37, 1'b0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL ignore_%h got seg=%h su=%b txv=%b mode=%b exp 37 0 0 0", ign[i], seg_data, seg_update, bus.tx_valid, mode_cmd);
            end
        end
    endtask

    task automatic test_cmd_ops();
        send(8'h4D);
        send(8'h5A);
        checks++;
        if ({mode_cmd, bus.tx_valid, bus.tx_data, rate_sel, pwm_en, rate_update} !== {1'b1, 1'b1, 8'h3F, 2'b01, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL nak got mode=%b txv=%b txd=%h rate=%b pwm=%b ru=%b", mode_cmd, bus.tx_valid, bus.tx_data, rate_sel, pwm_en, rate_update);
        end
        send(8'h70);
        checks++;
        if ({pwm_en, bus.tx_data} !== {1'b0, 8'h4B}) begin
            failures++;
            $display("FAIL pwm_off got pwm=%b txd=%h exp 0 4b", pwm_en, bus.tx_data);
        end
        send(8'h0A);
        tick();
        checks++;
        if ({bus.tx_valid, mode_cmd} !== {1'b0, 1'b1}) begin
            failures++;
            $display("FAIL cmd_ignore_lf got txv=%b mode=%b exp 0 1", bus.tx_valid, mode_cmd);
        end
        send(8'h41);
        checks++;
        if ({rate_sel, rate_update, seg_data} !== {2'b10, 1'b1, 8'h37}) begin
            failures++;
            $display("FAIL rate_fast got rate=%b ru=%b seg=%h exp 10 1 37", rate_sel, rate_update, seg_data);
        end
        send(8'h66);
        checks++;
        if ({mode_cmd, rate_sel, pwm_en, seg_data, bus.tx_data} !== {1'b0, 2'b10, 1'b0, 8'h37, 8'h4B}) begin
            failures++;
            $display("FAIL exit_keep got mode=%b rate=%b pwm=%b seg=%h txd=%h", mode_cmd, rate_sel, pwm_en, seg_data, bus.tx_data);
        end
        send(8'h53);
        checks++;
        if ({seg_data, pwm_en} !== {8'h53, 1'b0}) begin
            failures++;
            $display("FAIL normal_s_is_data got seg=%h pwm=%b exp 53 0", seg_data, pwm_en);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        send(8'h6D);
        while (mode_cmd === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16 || {bus.tx_valid, bus.tx_data} !== {1'b1, 8'h54}) begin
            failures++;
            $display("FAIL timeout got cycles=%0d txv=%b txd=%h exp 16 1 54", n, bus.tx_valid, bus.tx_data);
        end
        send(8'h6D);
        for (int i = 0; i < 15; i++) tick();
        send(8'h31);
        checks++;
        if ({mode_cmd, rate_sel, rate_update, bus.tx_data} !== {1'b1, 2'b00, 1'b1, 8'h4B}) begin
            failures++;
            $display("FAIL expiry_with_byte got mode=%b rate=%b ru=%b txd=%h exp 1 00 1 4b", mode_cmd, rate_sel, rate_update, bus.tx_data);
        end
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (mode_cmd !== 1'b1) begin
            failures++;
            $display("FAIL counter_restart got mode=%b exp 1", mode_cmd);
        end
        send(8'h66);
        tick();
    endtask

    task automatic test_back_to_back();
        int hs = 0;
        bus.tx_ready = 1'b0;
        send(8'h6D);
        send(8'h5A);
        checks++;
        if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h3F}) begin
            failures++;
            $display("FAIL overwrite_nak got txv=%b txd=%h exp 1 3f", bus.tx_valid, bus.tx_data);
        end
        send(8'h31);
        tick();
        tick();
        checks++;
        if ({bus.tx_valid, bus.tx_data, rate_sel, mode_cmd} !== {1'b1, 8'h4B, 2'b00, 1'b1}) begin
            failures++;
            $display("FAIL held_latest got txv=%b txd=%h rate=%b mode=%b exp 1 4b 00 1", bus.tx_valid, bus.tx_data, rate_sel, mode_cmd);
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.tx_valid === 1'b1) hs++;
            tick();
        end
        checks++;
        if (hs != 1 || bus.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_handshake got hs=%0d txv=%b exp 1 0", hs, bus.tx_valid);
        end
        bus.tx_ready = 1'b0;
        send(8'h5A);
        bus.tx_ready = 1'b1;
        send(8'h70);
        bus.tx_ready = 1'b0;
        checks++;
        if ({bus.tx_valid, bus.tx_data, pwm_en} !== {1'b1, 8'h4B, 1'b0}) begin
            failures++;
            $display("FAIL drain_and_load got txv=%b txd=%h pwm=%b exp 1 4b 0", bus.tx_valid, bus.tx_data, pwm_en);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h61);
        reset = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h53;
        tick();
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        checks++;
        if ({mode_cmd, seg_data, rate_sel, pwm_en, seg_update, rate_update, bus.tx_valid, bus.tx_data} !== {1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_mid got mode=%b seg=%h rate=%b pwm=%b su=%b ru=%b txv=%b txd=%h", mode_cmd, seg_data, rate_sel, pwm_en, seg_update, rate_update, bus.tx_valid, bus.tx_data);
        end
        tick();
        checks++;
        if ({seg_data, bus.tx_valid, mode_cmd} !== {8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_swallow got seg=%h txv=%b mode=%b exp 00 0 0", seg_data, bus.tx_valid, mode_cmd);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_entry();
        test_normal();
        test_cmd_ops();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
